crypt_sequencer: RTL and testbench
==================================

// Module: crypt_sequencer
// PURPOSE
//  Multi-cycle sequencer for the ENC/DEC R-type instructions (opcode 6'h00, funct 6'h30/6'h31).
//  On decode it freezes PC and register-file writes, runs ROUNDS keyed rounds over rs, then
//  presents the result on the RegWriteSrc=2'b11 (Crypt) writeback path for exactly one cycle.
//  Sits beside the control unit; its stall output gates PC update and RegWrite.
// PARAMETERS
//  ROUNDS  8  number of rounds per instruction (1..16); round index width IDX_W = 4
//  ROT     3  per-round rotate amount (1..31)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous active-low reset
//  instr_valid   in   1   instruction at PC is live this cycle
//  opcode        in   6   instr[31:26]
//  funct         in   6   instr[5:0]
//  src_data      in   32  rs value (plaintext/ciphertext)
//  src_key       in   32  rt value (key)
//  stall         out  1   hold PC, suppress RegWrite (combinational)
//  busy          out  1   state != IDLE
//  round_idx     out  4   current round number, 0 when not RUN
//  result        out  32  crypt output to writeback mux
//  result_valid  out  1   result is final; writeback may occur this cycle
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE; result, round_idx, data/key/mode regs = 0; busy=0;
//   result_valid=0. stall=0 during reset. Reset mid-operation abandons the op; no writeback.
//  is_crypt = instr_valid & opcode==6'h00 & (funct==6'h30 | funct==6'h31); mode = funct[0] (1 = DEC).
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: stall = is_crypt. If is_crypt: latch x<=src_data, key<=src_key, mode, idx<=0; go RUN.
//   RUN:  stall=1. Each cycle x<=round(x,k_j,mode), idx<=idx+1. After round ROUNDS-1, go DONE.
//         instr_valid/opcode/funct are ignored (the instruction is held by stall).
//   DONE: stall=0, result_valid=1, result=x; PC advances and rd is written at this edge; go IDLE.
//         is_crypt is not re-evaluated in DONE, so a held instruction never re-triggers.
//  Latency: ROUNDS+2 cycles per crypt instruction (1 decode + ROUNDS + 1 writeback).
//   Back-to-back crypt instructions: second starts in the IDLE cycle after DONE.
//  Round-key schedule: k_i = rol(key, i) ^ {28'b0, i[3:0]}; ENC uses j=idx, DEC uses j=ROUNDS-1-idx.
//  Round: ENC x' = rol(x ^ k, ROT) + k; DEC x' = ror(x - k, ROT) ^ k. All arithmetic mod 2^32,
//   so DEC with the same key exactly inverts ENC.
//  result holds its value after DONE until the next DONE; result_valid is high only in DONE.
//  Non-crypt instructions: stall=0, state stays IDLE, outputs unchanged.
// STRUCTURE
//  Shared header crypt_defs.vh (package): OPC_RTYPE=6'h00, FUNCT_ENC=6'h30, FUNCT_DEC=6'h31,
//   state encodings S_IDLE/S_RUN/S_DONE (2-bit), RWSRC_CRYPT=2'b11, default ROUNDS/ROT.
//  Sub-module crypt_round: combinational (x, key, idx, mode) -> x' including key schedule.
//  Top: FSM, round counter, x/key/mode registers, output decode.
// TESTING
//  1 ROUNDS=1: ENC src_data=1, key=0 -> stall high 2 cycles, result=32'h8 with result_valid 1 cycle.
//  2 ROUNDS=2: ENC data=0, key=0 -> result=32'h9 (k0=0, k1=1) after 4 cycles total.
//  3 ROUNDS=8: ENC key=32'hDEADBEEF, data=32'h12345678, then DEC of that result with same key
//    -> 32'h12345678; each op takes 10 cycles; round_idx sequences 0..7.
//  4 Non-crypt (add, funct 6'h20) and funct 6'h30 with instr_valid=0 -> stall=0, busy=0.
//  5 rst_n low in cycle 3 of RUN -> next cycle IDLE, stall=0, result=0, result_valid never pulses.
//  6 Two consecutive ENC instructions -> two DONE pulses exactly ROUNDS+2 cycles apart.

Source files
------------

// File: rtl/crypt_sequencer_pkg.sv
// Shared constants, state encoding and rotate helpers for the ENC/DEC crypt sequencer.
package crypt_sequencer_pkg;

  localparam logic [5:0] OPC_RTYPE   = 6'h00;
  localparam logic [5:0] FUNCT_ENC   = 6'h30;
  localparam logic [5:0] FUNCT_DEC   = 6'h31;
  localparam logic [1:0] RWSRC_CRYPT = 2'b11;
  localparam int         DEF_ROUNDS  = 8;
  localparam int         DEF_ROT     = 3;
  localparam int         IDX_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Rotates go through a doubled word so a zero amount needs no special case.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] d;
    d = {v, v} << sh;
    return d[63:32];
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] d;
    d = {v, v} >> sh;
    return d[31:0];
  endfunction

endpackage

// File: rtl/crypt_sequencer_round.sv
// One keyed round including the round-key schedule; DEC walks the key schedule backwards.
module crypt_round
  import crypt_sequencer_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int ROT    = DEF_ROT
) (
  input  logic [31:0]      x_i,
  input  logic [31:0]      key_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             mode_i,
  output logic [31:0]      x_o
);

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(ROUNDS - 1);
  localparam logic [4:0]       ROT_AMT = 5'(ROT);

  logic [IDX_W-1:0] j;
  logic [31:0]      k;

  always_comb begin
    j = mode_i ? (LAST - idx_i) : idx_i;
    k = rol32(key_i, {1'b0, j}) ^ {28'b0, j};
    if (mode_i) begin
      x_o = ror32(x_i - k, ROT_AMT) ^ k;
    end else begin
      x_o = rol32(x_i ^ k, ROT_AMT) + k;
    end
  end

endmodule

// File: rtl/crypt_sequencer.sv
// Multi-cycle ENC/DEC sequencer: stalls the pipeline front end while ROUNDS rounds run,
// then offers the result to the writeback mux for a single cycle.
module crypt_sequencer
  import crypt_sequencer_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int ROT    = DEF_ROT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [31:0]      src_data,
  input  logic [31:0]      src_key,
  output logic             stall,
  output logic             busy,
  output logic [IDX_W-1:0] round_idx,
  output logic [31:0]      result,
  output logic             result_valid
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      key_q, key_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      round_x;
  logic             is_crypt;
  logic             stall_raw;

  assign is_crypt = instr_valid && (opcode == OPC_RTYPE) &&
                    ((funct == FUNCT_ENC) || (funct == FUNCT_DEC));

  crypt_round #(.ROUNDS(ROUNDS), .ROT(ROT)) u_round (
    .x_i   (x_q),
    .key_i (key_q),
    .idx_i (idx_q),
    .mode_i(mode_q),
    .x_o   (round_x)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    key_d        = key_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    result_d     = result_q;
    stall_raw    = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_raw = is_crypt;
        if (is_crypt) begin
          x_d     = src_data;
          key_d   = src_key;
          mode_d  = funct[0];
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        stall_raw = 1'b1;
        x_d       = round_x;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        result_d     = x_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // The final value is visible in DONE itself, before it lands in result_q.
  assign stall     = stall_raw && rst_n;
  assign busy      = (state_q != S_IDLE);
  assign round_idx = (state_q == S_RUN) ? idx_q : '0;
  assign result    = (state_q == S_DONE) ? x_q : result_q;

endmodule

// File: tb/tb_crypt_sequencer.sv
// Directed bench for crypt_sequencer with three instances (ROUNDS = 1, 2, 8).
module tb_crypt_sequencer;

  logic        clk = 1'b0;
  logic        rstN       [3];
  logic        instrValid [3];
  logic [5:0]  opcode     [3];
  logic [5:0]  funct      [3];
  logic [31:0] srcData    [3];
  logic [31:0] srcKey     [3];
  logic        stall      [3];
  logic        busy       [3];
  logic [3:0]  roundIdx   [3];
  logic [31:0] result     [3];
  logic        resultValid[3];

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  crypt_sequencer #(.ROUNDS(1), .ROT(3)) dut1 (
    .clk(clk), .rst_n(rstN[0]), .instr_valid(instrValid[0]), .opcode(opcode[0]),
    .funct(funct[0]), .src_data(srcData[0]), .src_key(srcKey[0]), .stall(stall[0]),
    .busy(busy[0]), .round_idx(roundIdx[0]), .result(result[0]), .result_valid(resultValid[0]));

  crypt_sequencer #(.ROUNDS(2), .ROT(3)) dut2 (
    .clk(clk), .rst_n(rstN[1]), .instr_valid(instrValid[1]), .opcode(opcode[1]),
    .funct(funct[1]), .src_data(srcData[1]), .src_key(srcKey[1]), .stall(stall[1]),
    .busy(busy[1]), .round_idx(roundIdx[1]), .result(result[1]), .result_valid(resultValid[1]));

  crypt_sequencer #(.ROUNDS(8), .ROT(3)) dut8 (
    .clk(clk), .rst_n(rstN[2]), .instr_valid(instrValid[2]), .opcode(opcode[2]),
    .funct(funct[2]), .src_data(srcData[2]), .src_key(srcKey[2]), .stall(stall[2]),
    .busy(busy[2]), .round_idx(roundIdx[2]), .result(result[2]), .result_valid(resultValid[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rolM(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] modelEnc(input logic [31:0] d, input logic [31:0] k, input int rounds);
    logic [31:0] x, rk;
    x = d;
    for (int i = 0; i < rounds; i++) begin
      rk = rolM(k, i) ^ 32'(i);
      x  = rolM(x ^ rk, 3) + rk;
    end
    return x;
  endfunction

  task automatic applyStimulus(input int u, input logic v, input logic [5:0] fn,
                               input logic [31:0] d, input logic [31:0] k);
    instrValid[u] = v;
    opcode[u]     = 6'h00;
    funct[u]      = fn;
    srcData[u]    = d;
    srcKey[u]     = k;
  endtask

  // Hold one instruction until writeback, counting cycles, stalls and round_idx errors.
  task automatic runOp(input int u, input logic [5:0] fn, input logic [31:0] d, input logic [31:0] k,
                       output int cycles, output int stalls, output int idxBad, output logic [31:0] res);
    bit done = 0;
    cycles = 0; stalls = 0; idxBad = 0; res = '0;
    applyStimulus(u, 1'b1, fn, d, k);
    #1;
    while (!done && cycles < 40) begin
      cycles++;
      if (stall[u]) stalls++;
      if (cycles >= 2 && !resultValid[u] && roundIdx[u] != 4'(cycles - 2)) idxBad++;
      if (resultValid[u]) begin
        res  = result[u];
        done = 1;
      end else begin
        tick();
      end
    end
    if (!done) checkOutput("runOpTimeout", 32'(cycles), 32'hFFFFFFFF);
    instrValid[u] = 1'b0;
    tick();
  endtask

  initial begin
    int cyc, stl, ib, pulses, firstT, secondT;
    logic [31:0] res, encRes;
    for (int u = 0; u < 3; u++) begin
      rstN[u] = 1'b0;
      applyStimulus(u, 1'b0, 6'h00, '0, '0);
    end
    tick(); tick();
    for (int u = 0; u < 3; u++) begin
      checkOutput($sformatf("rstBusy%0d", u), 32'(busy[u]), 32'h0);
      checkOutput($sformatf("rstStall%0d", u), 32'(stall[u]), 32'h0);
      checkOutput($sformatf("rstResult%0d", u), result[u], 32'h0);
      checkOutput($sformatf("rstValid%0d", u), 32'(resultValid[u]), 32'h0);
      checkOutput($sformatf("rstIdx%0d", u), 32'(roundIdx[u]), 32'h0);
      rstN[u] = 1'b1;
    end
    tick();

    runOp(0, 6'h30, 32'h1, 32'h0, cyc, stl, ib, res);
    checkOutput("r1Result", res, 32'h8);
    checkOutput("r1Cycles", 32'(cyc), 32'd3);
    checkOutput("r1Stalls", 32'(stl), 32'd2);
    checkOutput("r1ValidDrop", 32'(resultValid[0]), 32'h0);
    checkOutput("r1Hold", result[0], 32'h8);
    checkOutput("r1BusyAfter", 32'(busy[0]), 32'h0);

    runOp(1, 6'h30, 32'h0, 32'h0, cyc, stl, ib, res);
    checkOutput("r2Result", res, 32'h9);
    checkOutput("r2Cycles", 32'(cyc), 32'd4);

    runOp(2, 6'h30, 32'h12345678, 32'hDEADBEEF, cyc, stl, ib, encRes);
    checkOutput("r8EncResult", encRes, modelEnc(32'h12345678, 32'hDEADBEEF, 8));
    checkOutput("r8EncCycles", 32'(cyc), 32'd10);
    checkOutput("r8EncIdxSeq", 32'(ib), 32'd0);
    runOp(2, 6'h31, encRes, 32'hDEADBEEF, cyc, stl, ib, res);
    checkOutput("r8DecResult", res, 32'h12345678);
    checkOutput("r8DecCycles", 32'(cyc), 32'd10);
    checkOutput("r8DecIdxSeq", 32'(ib), 32'd0);

    applyStimulus(2, 1'b1, 6'h20, 32'hFFFF0000, 32'h1);
    #1;
    checkOutput("addStall", 32'(stall[2]), 32'h0);
    tick();
    checkOutput("addBusy", 32'(busy[2]), 32'h0);
    checkOutput("addResult", result[2], 32'h12345678);
    applyStimulus(2, 1'b0, 6'h30, 32'hFFFF0000, 32'h1);
    #1;
    checkOutput("invalidStall", 32'(stall[2]), 32'h0);
    tick();
    checkOutput("invalidBusy", 32'(busy[2]), 32'h0);

    applyStimulus(2, 1'b1, 6'h30, 32'hCAFEF00D, 32'h01234567);
    pulses = 0; firstT = -1; secondT = -1;
    for (int t = 0; t < 22; t++) begin
      #1;
      if (resultValid[2]) begin
        pulses++;
        if (firstT < 0) firstT = t; else if (secondT < 0) secondT = t;
        checkOutput("b2bResult", result[2], modelEnc(32'hCAFEF00D, 32'h01234567, 8));
      end
      tick();
    end
    instrValid[2] = 1'b0;
    checkOutput("b2bPulses", 32'(pulses), 32'd2);
    checkOutput("b2bGap", 32'(secondT - firstT), 32'd10);
    tick(); tick();

    applyStimulus(2, 1'b1, 6'h30, 32'h0BADF00D, 32'h55AA55AA);
    tick(); tick(); tick();
    rstN[2] = 1'b0;
    #1;
    checkOutput("midRstStall", 32'(stall[2]), 32'h0);
    tick();
    rstN[2] = 1'b1;
    instrValid[2] = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy[2]), 32'h0);
    checkOutput("midRstStallAfter", 32'(stall[2]), 32'h0);
    checkOutput("midRstResult", result[2], 32'h0);
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      if (resultValid[2]) pulses++;
      tick();
    end
    checkOutput("midRstNoPulse", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
